// File: rtl/effects_pkg.sv
// Shared definitions for the codec/effect bridge: sample width, FSM states, default timeout.
package effects_pkg;

    localparam int SAMPLE_W        = 12;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        CAPTURE
    } state_t;

endpackage

// File: rtl/decimating_accumulator.sv
// Sums DECIM codec samples and emits their average with a one-cycle avg_valid.
// Define ROUND_EN for round-half-up with positive saturation; default truncates toward -inf.
module decimating_accumulator
    import effects_pkg::*;
#(
    parameter int DECIM     = 2,
    parameter int LOG_DECIM = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ready,
    input  logic signed [SAMPLE_W-1:0] from_codec,
    output logic signed [SAMPLE_W-1:0] avg,
    output logic                       avg_valid
);

    localparam int ACC_W = SAMPLE_W + LOG_DECIM;
`ifdef ROUND_EN
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] ROUND_K = SUM_W'(1 << (LOG_DECIM - 1));
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (SAMPLE_W - 1) - 1);
`else
    localparam int SUM_W = ACC_W;
`endif

    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic        [LOG_DECIM-1:0] phase_q, phase_d;
    logic signed [ACC_W-1:0]     raw;
    logic signed [SUM_W-1:0]     shifted;

    always_comb begin
        acc_d     = acc_q;
        phase_d   = phase_q;
        avg_valid = 1'b0;
        raw       = acc_q + ACC_W'(from_codec);
`ifdef ROUND_EN
        shifted = (SUM_W'(raw) + ROUND_K) >>> LOG_DECIM;
        if (shifted > SAT_MAX) begin
            avg = SAMPLE_W'(SAT_MAX);
        end else begin
            avg = SAMPLE_W'(shifted);
        end
`else
        shifted = raw >>> LOG_DECIM;
        avg     = SAMPLE_W'(shifted);
`endif
        if (ready) begin
            if (phase_q == LOG_DECIM'(DECIM - 1)) begin
                acc_d     = '0;
                phase_d   = '0;
                avg_valid = 1'b1;
            end else begin
                acc_d   = raw;
                phase_d = phase_q + LOG_DECIM'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/decimate_start_sequencer.sv
// Bridges the codec sample strobe to the effect stage: decimate, start, wait for done, hold result.
// ROUND_EN (see decimating_accumulator) selects rounding of the decimated sample.
module decimate_start_sequencer
    import effects_pkg::*;
#(
    parameter int DECIM          = 2,
    parameter int LOG_DECIM      = 1,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ready,
    input  logic signed [SAMPLE_W-1:0] from_codec,
    input  logic                       clear_flags,
    output logic                       effect_start,
    output logic signed [SAMPLE_W-1:0] effect_sample,
    input  logic                       effect_done,
    input  logic signed [SAMPLE_W-1:0] effect_result,
    output logic signed [SAMPLE_W-1:0] to_codec,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic signed [SAMPLE_W-1:0] avg;
    logic                       avg_valid;

    state_t                     state_q, state_d;
    logic signed [SAMPLE_W-1:0] effect_sample_q, effect_sample_d;
    logic signed [SAMPLE_W-1:0] to_codec_q, to_codec_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_q, timeout_d;
    logic        [TO_W-1:0]     tcnt_q, tcnt_d;

    decimating_accumulator #(
        .DECIM     (DECIM),
        .LOG_DECIM (LOG_DECIM)
    ) u_accum (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .from_codec (from_codec),
        .avg        (avg),
        .avg_valid  (avg_valid)
    );

    always_comb begin
        state_d         = state_q;
        effect_sample_d = effect_sample_q;
        to_codec_d      = to_codec_q;
        overrun_d       = overrun_q;
        timeout_d       = timeout_q;
        tcnt_d          = tcnt_q;
        effect_start    = 1'b0;

        // Clear is applied first so a same-cycle set takes priority.
        if (clear_flags) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (avg_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (avg_valid) begin
                    effect_sample_d = avg;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                effect_start = 1'b1;
                tcnt_d       = '0;
                state_d      = ARM;
            end
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                tcnt_d = tcnt_q + TO_W'(1);
                if (effect_done) begin
                    state_d = CAPTURE;
                end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d  = 1'b1;
                    to_codec_d = effect_sample_q;
                    state_d    = IDLE;
                end
            end
            CAPTURE: begin
                to_codec_d = effect_result;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            effect_sample_q <= '0;
            to_codec_q      <= '0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
            tcnt_q          <= '0;
        end else begin
            state_q         <= state_d;
            effect_sample_q <= effect_sample_d;
            to_codec_q      <= to_codec_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
            tcnt_q          <= tcnt_d;
        end
    end

    assign effect_sample = effect_sample_q;
    assign to_codec      = to_codec_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_decimate_start_sequencer.sv
// Scoreboard bench for decimate_start_sequencer (DECIM=2, TIMEOUT_CYCLES=16); honours ROUND_EN.
module tb_decimate_start_sequencer;

    localparam int TMO = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              ready;
    logic signed [11:0] from_codec;
    logic              clear_flags;
    logic              effect_start;
    logic signed [11:0] effect_sample;
    logic              effect_done = 1'b0;
    logic signed [11:0] effect_result = '0;
    logic signed [11:0] to_codec;
    logic              busy;
    logic              overrun;
    logic              timeout;

    int passed = 0;
    int total  = 0;
    int starts = 0;
    int exp_q[$];
    int sb_e;

    int         mode = 2;   // 0: done after dly cycles, 1: bypass (done high), 2: never done
    int         dly  = 5;
    int         cnt  = 0;
    logic [11:0] mask = '0;

    decimate_start_sequencer #(
        .DECIM          (2),
        .LOG_DECIM      (1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ready         (ready),
        .from_codec    (from_codec),
        .clear_flags   (clear_flags),
        .effect_start  (effect_start),
        .effect_sample (effect_sample),
        .effect_done   (effect_done),
        .effect_result (effect_result),
        .to_codec      (to_codec),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    always #5 clock = ~clock;

    // Effect stage model.
    always @(posedge clock) begin
        case (mode)
            0: begin
                if (effect_start) begin
                    effect_done <= 1'b0;
                    cnt         <= dly;
                end else if (cnt > 0) begin
                    cnt <= cnt - 1;
                    if (cnt == 1) begin
                        effect_done   <= 1'b1;
                        effect_result <= effect_sample ^ mask;
                    end
                end
            end
            1: begin
                effect_done   <= 1'b1;
                effect_result <= effect_sample ^ mask;
            end
            default: effect_done <= 1'b0;
        endcase
    end

    // Scoreboard: every start pulse must carry the next expected decimated sample.
    always @(negedge clock) begin
        if (effect_start === 1'b1) begin
            starts++;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_start: unexpected effect_start with sample %0d, required no pulse", effect_sample);
            end else begin
                sb_e = exp_q.pop_front();
                if (effect_sample !== 12'(sb_e))
                    $display("FAIL sb_sample: effect_sample=%0d required %0d", effect_sample, sb_e);
                else
                    passed++;
            end
        end
    end

    function automatic int exp_avg(input int a, input int b);
        int s;
        int q;
        s = a + b;
`ifdef ROUND_EN
        s = s + 1;
`endif
        q = (s >= 0) ? s / 2 : -((-s + 1) / 2);
`ifdef ROUND_EN
        if (q > 2047) q = 2047;
`endif
        return q;
    endfunction

    task automatic drive_sample(input int v);
        @(posedge clock); #1;
        ready      = 1'b1;
        from_codec = 12'(v);
        @(posedge clock); #1;
        ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) $display("FAIL %s_idle: busy still %b after 60 cycles, required 0", name, busy);
        else passed++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        total++;
        if ({effect_start, effect_sample, to_codec, busy, overrun, timeout} !== 28'd0)
            $display("FAIL reset_held: outputs=%h required 0", {effect_start, effect_sample, to_codec, busy, overrun, timeout});
        else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({effect_start, effect_sample, to_codec, busy, overrun, timeout} !== 28'd0)
            $display("FAIL reset_release: outputs=%h required 0", {effect_start, effect_sample, to_codec, busy, overrun, timeout});
        else passed++;
    endtask

    task automatic test_basic;
        int s0;
        mode = 0; dly = 5; mask = '0;
        s0 = starts;
        exp_q.push_back(exp_avg(100, 300));
        drive_sample(100);
        drive_sample(300);
        @(negedge clock);
        total++;
        if ({effect_start, busy} !== 2'b11)
            $display("FAIL basic_latency: start,busy=%b required 11", {effect_start, busy});
        else passed++;
        wait_idle("basic");
        total++;
        if (to_codec !== 12'sd200) $display("FAIL basic_result: to_codec=%0d required 200", to_codec);
        else passed++;
        repeat (10) @(negedge clock);
        total++;
        if (to_codec !== 12'sd200) $display("FAIL basic_hold: to_codec=%0d required 200", to_codec);
        else passed++;
        total++;
        if (starts - s0 !== 1) $display("FAIL basic_pulses: %0d start pulses, required 1", starts - s0);
        else passed++;
    endtask

    task automatic test_neg_trunc;
        int e;
        e = exp_avg(-1, -2);
        exp_q.push_back(e);
        drive_sample(-1);
        drive_sample(-2);
        wait_idle("neg");
        total++;
        if (to_codec !== 12'(e)) $display("FAIL neg_result: to_codec=%0d required %0d", to_codec, e);
        else passed++;
    endtask

    task automatic test_bypass;
        logic signed [11:0] prev;
        mode = 1;
        repeat (2) @(negedge clock);
        prev = to_codec;
        exp_q.push_back(exp_avg(1000, 1000));
        drive_sample(1000);
        drive_sample(1000);
        @(negedge clock);
        total++;
        if (effect_start !== 1'b1) $display("FAIL bypass_start: effect_start=%b required 1", effect_start);
        else passed++;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, to_codec} !== {1'b1, prev})
            $display("FAIL bypass_early: busy=%b to_codec=%0d required 1/%0d", busy, to_codec, prev);
        else passed++;
        @(negedge clock);
        total++;
        if ({busy, to_codec} !== {1'b0, 12'sd1000})
            $display("FAIL bypass_capture: busy=%b to_codec=%0d required 0/1000", busy, to_codec);
        else passed++;
    endtask

    task automatic test_timeout;
        mode = 2;
        repeat (2) @(negedge clock);
        exp_q.push_back(exp_avg(50, 50));
        drive_sample(50);
        drive_sample(50);
        @(negedge clock);
        repeat (17) @(negedge clock);
        total++;
        if ({timeout, busy} !== 2'b01)
            $display("FAIL timeout_early: timeout,busy=%b required 01", {timeout, busy});
        else passed++;
        @(negedge clock);
        total++;
        if ({timeout, busy, to_codec} !== {2'b10, 12'sd50})
            $display("FAIL timeout_fire: timeout,busy=%b to_codec=%0d required 10/50", {timeout, busy}, to_codec);
        else passed++;
        @(posedge clock); #1 clear_flags = 1'b1;
        @(posedge clock); #1 clear_flags = 1'b0;
        @(negedge clock);
        total++;
        if (timeout !== 1'b0) $display("FAIL timeout_clear: timeout=%b required 0", timeout);
        else passed++;
    endtask

    task automatic test_overrun;
        int s0;
        mode = 0; dly = 8; mask = 12'h055;
        s0 = starts;
        exp_q.push_back(exp_avg(10, 20));
        drive_sample(10);
        drive_sample(20);
        drive_sample(400);
        drive_sample(400);
        @(negedge clock);
        total++;
        if ({overrun, busy} !== 2'b11)
            $display("FAIL overrun_set: overrun,busy=%b required 11", {overrun, busy});
        else passed++;
        wait_idle("overrun");
        total++;
        if (to_codec !== (12'(exp_avg(10, 20)) ^ mask))
            $display("FAIL overrun_result: to_codec=%0d required %0d", to_codec, 12'(exp_avg(10, 20)) ^ mask);
        else passed++;
        repeat (5) @(negedge clock);
        total++;
        if (starts - s0 !== 1) $display("FAIL overrun_pulses: %0d start pulses, required 1", starts - s0);
        else passed++;
        @(posedge clock); #1 clear_flags = 1'b1;
        @(posedge clock); #1 clear_flags = 1'b0;
        @(negedge clock);
        total++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: overrun=%b required 0", overrun);
        else passed++;
        // Clear and a dropped sample on the same cycle: the set must win.
        exp_q.push_back(exp_avg(6, 8));
        drive_sample(6);
        drive_sample(8);
        @(posedge clock); #1 ready = 1'b1; from_codec = 12'sd2;
        @(posedge clock); #1 ready = 1'b0;
        @(posedge clock); #1 ready = 1'b1; from_codec = 12'sd4; clear_flags = 1'b1;
        @(posedge clock); #1 ready = 1'b0; clear_flags = 1'b0;
        @(negedge clock);
        total++;
        if (overrun !== 1'b1) $display("FAIL overrun_set_wins: overrun=%b required 1", overrun);
        else passed++;
        wait_idle("overrun2");
    endtask

    task automatic test_reset_mid;
        mode = 2;
        exp_q.push_back(exp_avg(500, 100));
        drive_sample(500);
        drive_sample(100);
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({effect_start, effect_sample, to_codec, busy, overrun, timeout} !== 28'd0)
            $display("FAIL reset_wait: outputs=%h required 0", {effect_start, effect_sample, to_codec, busy, overrun, timeout});
        else passed++;
        @(negedge clock) reset = 1'b0;
        drive_sample(11);
        drive_sample(13);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({effect_start, busy} !== 2'b00)
            $display("FAIL reset_abort_start: start,busy=%b required 00", {effect_start, busy});
        else passed++;
        @(negedge clock) reset = 1'b0;
        exp_q.delete();
        drive_sample(77);
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        mode = 0; dly = 5; mask = '0;
        exp_q.push_back(exp_avg(30, 40));
        drive_sample(30);
        drive_sample(40);
        wait_idle("after_reset");
        total++;
        if ({to_codec, overrun, timeout} !== {12'(exp_avg(30, 40)), 2'b00})
            $display("FAIL after_reset_result: to_codec=%0d ov=%b to=%b required %0d/0/0", to_codec, overrun, timeout, exp_avg(30, 40));
        else passed++;
    endtask

    initial begin
        reset       = 1'b1;
        ready       = 1'b0;
        from_codec  = '0;
        clear_flags = 1'b0;
        test_reset();
        test_basic();
        test_neg_trunc();
        test_bypass();
        test_timeout();
        test_overrun();
        test_reset_mid();
        repeat (3) @(negedge clock);
        total++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d expected samples never issued, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
